stopwatch_core: RTL and testbench

Timekeeping stage that produces the 39-bit `time_in` millisecond value consumed by the seven-segment display path. It counts elapsed time up as a stopwatch, or down from a loaded value as a countdown timer, and supports start/stop, lap freeze and clear. Control inputs are single-cycle pulses from the debounced-button stage. Timing uses a clock-enable tick, not a derived clock, so the whole block runs on `clock`.

---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/stopwatch_core_ms_tick_gen.sv | 38 +++
 rtl/stopwatch_core.sv | 153 +++++++++++++++
 tb/tb_stopwatch_core.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Definitions shared by the stopwatch core and the display stage:
//   - sw_state_t       : core FSM states (IDLE, RUNNING, PAUSED, DONE)
//   - TIME_W           : width of every millisecond value (39 bits)
//   - MAX_MS_DEFAULT   : wrap modulus in ms (one hour)
//   - TICK_DIV_DEFAULT : clock cycles per ms tick on the 100 MHz board clock
//   - clamp_load()     : limits a countdown start value to max_ms-1
package stopwatch_pkg;

   localparam int TIME_W           = 39;
   localparam int MAX_MS_DEFAULT   = 3_600_000;
   localparam int TICK_DIV_DEFAULT = 100_000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_DONE    = 2'd3
   } sw_state_t;

   function automatic logic [TIME_W-1:0] clamp_load(input logic [TIME_W-1:0] value,
                                                     input logic [TIME_W-1:0] max_ms);
      return (value >= max_ms) ? (max_ms - TIME_W'(1)) : value;
   endfunction

endpackage

// File: rtl/stopwatch_core_ms_tick_gen.sv
// ms_tick_gen
// Millisecond prescaler. Counts 0..TICK_DIV-1 while en is high and holds
// its phase while en is low, so pausing never loses a partial millisecond.
// Ports:
//   clock : system clock
//   reset : synchronous active-high reset, phase back to 0
//   clr   : synchronous clear, phase back to 0 (wins over en)
//   en    : count enable
//   tick  : one-cycle pulse on the enabled cycle whose phase is TICK_DIV-1
module ms_tick_gen #(
   parameter int TICK_DIV = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clock) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (en) begin
         if (cnt == LAST) cnt <= '0;
         else             cnt <= cnt + CNT_W'(1);
      end
   end

   // Decoded straight from the phase register so the counter update lands
   // on the same edge that wraps the phase.
   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core
// Stopwatch / countdown timer producing the millisecond value for the
// seven-segment display path.
// Ports:
//   clock      : system clock, all state on rising edge
//   reset      : synchronous active-high reset
//   start_stop : pulse, run/pause toggle (IDLE -> RUNNING starts a run)
//   lap        : pulse, freeze/release the displayed value
//   clear      : pulse, back to IDLE
//   mode       : 0 count up, 1 count down (sampled in IDLE)
//   load_ms    : countdown start value in ms (sampled in IDLE)
//   time_out   : displayed time in ms (lap register or counter)
//   running    : high in RUNNING
//   lap_active : high while the display is frozen
//   done       : high in DONE
//   fsm_state  : current FSM state (sw_state_t encoding), for observation
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEFAULT,
   parameter int MAX_MS   = MAX_MS_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start_stop,
   input  logic        lap,
   input  logic        clear,
   input  logic        mode,
   input  logic [38:0] load_ms,
   output logic [38:0] time_out,
   output logic        running,
   output logic        lap_active,
   output logic        done,
   output logic [1:0]  fsm_state
);

   localparam logic [TIME_W-1:0] MAX_LIM = TIME_W'(MAX_MS);
   localparam logic [TIME_W-1:0] MAX_M1  = TIME_W'(MAX_MS - 1);
   localparam logic [TIME_W-1:0] ONE     = TIME_W'(1);

   sw_state_t         state;
   logic [TIME_W-1:0] counter;
   logic [TIME_W-1:0] lap_reg;
   logic              mode_q;
   logic              tick;
   logic              tick_en;
   logic [TIME_W-1:0] reload_val;
   logic [TIME_W-1:0] cnt_next;
   logic              hit_zero;

   assign tick_en    = (state == ST_RUNNING);
   assign reload_val = mode ? clamp_load(load_ms, MAX_LIM) : '0;
   assign fsm_state  = state;

   ms_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clock (clock),
      .reset (reset),
      .clr   (clear),
      .en    (tick_en),
      .tick  (tick)
   );

   // Counter step used in RUNNING. A down-count already sitting at 0 ends
   // the run without waiting for a tick; otherwise the tick that takes it
   // from 1 to 0 ends it on that same edge.
   always_comb begin
      cnt_next = counter;
      hit_zero = 1'b0;
      if (mode_q) begin
         if (counter == '0) begin
            hit_zero = 1'b1;
         end else if (tick) begin
            cnt_next = counter - ONE;
            hit_zero = (counter == ONE);
         end
      end else if (tick) begin
         cnt_next = (counter >= MAX_M1) ? '0 : counter + ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         counter    <= '0;
         lap_reg    <= '0;
         lap_active <= 1'b0;
         mode_q     <= 1'b0;
         time_out   <= '0;
         running    <= 1'b0;
         done       <= 1'b0;
      end else begin
         // Display register trails the counter/lap register by one cycle.
         time_out <= lap_active ? lap_reg : counter;

         if (clear) begin
            state      <= ST_IDLE;
            counter    <= '0;
            lap_active <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b0;
         end else begin
            // Lap toggle: only meaningful while a run is in progress. The
            // capture uses the pre-edge counter even if a tick lands now.
            if (lap && (state == ST_RUNNING || state == ST_PAUSED)) begin
               if (!lap_active) begin
                  lap_reg    <= counter;
                  lap_active <= 1'b1;
               end else begin
                  lap_active <= 1'b0;
               end
            end

            case (state)
               ST_IDLE: begin
                  counter <= reload_val;
                  if (start_stop) begin
                     state   <= ST_RUNNING;
                     running <= 1'b1;
                     mode_q  <= mode;
                  end
               end
               ST_RUNNING: begin
                  counter <= cnt_next;
                  if (hit_zero) begin
                     // Overrides any lap toggle made on this edge.
                     state      <= ST_DONE;
                     counter    <= '0;
                     lap_active <= 1'b0;
                     running    <= 1'b0;
                     done       <= 1'b1;
                  end else if (start_stop) begin
                     state   <= ST_PAUSED;
                     running <= 1'b0;
                  end
               end
               ST_PAUSED: begin
                  if (start_stop) begin
                     state   <= ST_RUNNING;
                     running <= 1'b1;
                  end
               end
               default: begin
                  // DONE: parked at zero until clear or reset.
                  counter <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

   logic        clock;
   logic        reset;
   logic        start_stop;
   logic        lap;
   logic        clear;
   logic        mode;
   logic [38:0] load_ms;

   logic [38:0] time_out;
   logic        running;
   logic        lap_active;
   logic        done;
   logic [1:0]  fsm_state;

   logic [38:0] w_time_out;
   logic        w_running;
   logic        w_lap_active;
   logic        w_done;
   logic [1:0]  w_fsm_state;

   logic [38:0] exp_q[$];
   int          n_checks;
   int          n_fail;

   // Full-size instance: one-hour modulus, 4-cycle tick.
   stopwatch_core #(
      .TICK_DIV (4),
      .MAX_MS   (3_600_000)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start_stop (start_stop),
      .lap        (lap),
      .clear      (clear),
      .mode       (mode),
      .load_ms    (load_ms),
      .time_out   (time_out),
      .running    (running),
      .lap_active (lap_active),
      .done       (done),
      .fsm_state  (fsm_state)
   );

   // Short-modulus instance (wraps 5 -> 0) so the up-count wrap is reachable
   // in a few dozen cycles; same inputs as the main instance.
   stopwatch_core #(
      .TICK_DIV (4),
      .MAX_MS   (6)
   ) dut_w (
      .clock      (clock),
      .reset      (reset),
      .start_stop (start_stop),
      .lap        (lap),
      .clear      (clear),
      .mode       (mode),
      .load_ms    (load_ms),
      .time_out   (w_time_out),
      .running    (w_running),
      .lap_active (w_lap_active),
      .done       (w_done),
      .fsm_state  (w_fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
      mode = 1'b0; load_ms = '0;
      cyc(2);
      reset = 1'b0;
   endtask

   task automatic pulse_ss();
      start_stop = 1'b1;
      cyc(1);
      start_stop = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      n_checks++; if (time_out !== 39'd0) begin n_fail++; $display("FAIL reset_time_out: got %0d expected 0", time_out); end
      n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %0b expected 0", running); end
      n_checks++; if (lap_active !== 1'b0) begin n_fail++; $display("FAIL reset_lap_active: got %0b expected 0", lap_active); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
      n_checks++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
   endtask

   task automatic test_up_count();
      logic [38:0] exp_v;
      do_reset();
      mode = 1'b0;
      pulse_ss();
      n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL up_running: got %0b expected 1", running); end
      // Counter steps every 4th edge after the start edge; display trails by one.
      for (int k = 1; k <= 41; k++) exp_q.push_back(39'((k - 1) / 4));
      for (int k = 1; k <= 41; k++) begin
         cyc(1);
         exp_v = exp_q.pop_front();
         n_checks++; if (time_out !== exp_v) begin n_fail++; $display("FAIL up_count k=%0d: got %0d expected %0d", k, time_out, exp_v); end
      end
      pulse_ss();
      n_checks++; if (running !== 1'b0 || fsm_state !== 2'd2) begin n_fail++; $display("FAIL up_pause: got running=%0b state=%0d expected running=0 state=2", running, fsm_state); end
      for (int k = 0; k < 20; k++) exp_q.push_back(39'd10);
      for (int k = 0; k < 20; k++) begin
         cyc(1);
         exp_v = exp_q.pop_front();
         n_checks++; if (time_out !== exp_v) begin n_fail++; $display("FAIL up_hold k=%0d: got %0d expected %0d", k, time_out, exp_v); end
      end
      // Paused at phase 2: resume needs only two more running edges for the tick.
      pulse_ss();
      exp_q.push_back(39'd10); exp_q.push_back(39'd10); exp_q.push_back(39'd11);
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         exp_v = exp_q.pop_front();
         n_checks++; if (time_out !== exp_v) begin n_fail++; $display("FAIL up_resume_phase k=%0d: got %0d expected %0d", k, time_out, exp_v); end
      end
   endtask

   task automatic test_wrap();
      logic [38:0] exp_v;
      do_reset();
      mode = 1'b0;
      pulse_ss();
      for (int k = 1; k <= 30; k++) exp_q.push_back(39'(((k - 1) / 4) % 6));
      for (int k = 1; k <= 30; k++) begin
         cyc(1);
         exp_v = exp_q.pop_front();
         n_checks++; if (w_time_out !== exp_v) begin n_fail++; $display("FAIL wrap k=%0d: got %0d expected %0d", k, w_time_out, exp_v); end
      end
      n_checks++; if (w_done !== 1'b0 || w_running !== 1'b1) begin n_fail++; $display("FAIL wrap_status: got done=%0b running=%0b expected done=0 running=1", w_done, w_running); end
   endtask

   task automatic test_countdown();
      logic [38:0] exp_v;
      do_reset();
      mode = 1'b1; load_ms = 39'd3;
      cyc(2);
      n_checks++; if (time_out !== 39'd3) begin n_fail++; $display("FAIL down_idle_load: got %0d expected 3", time_out); end
      pulse_ss();
      for (int k = 1; k <= 13; k++) exp_q.push_back(39'(3 - (k - 1) / 4));
      for (int k = 1; k <= 13; k++) begin
         cyc(1);
         exp_v = exp_q.pop_front();
         n_checks++; if (time_out !== exp_v) begin n_fail++; $display("FAIL down_count k=%0d: got %0d expected %0d", k, time_out, exp_v); end
         if (k == 11) begin
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL down_done_early: got %0b expected 0", done); end
         end
         if (k == 12) begin
            n_checks++; if (done !== 1'b1 || running !== 1'b0) begin n_fail++; $display("FAIL down_done_edge: got done=%0b running=%0b expected done=1 running=0", done, running); end
         end
      end
      start_stop = 1'b1; lap = 1'b1;
      cyc(1);
      start_stop = 1'b0; lap = 1'b0;
      cyc(2);
      n_checks++; if (fsm_state !== 2'd3 || done !== 1'b1 || lap_active !== 1'b0) begin n_fail++; $display("FAIL done_ignores: got state=%0d done=%0b lap=%0b expected state=3 done=1 lap=0", fsm_state, done, lap_active); end
      n_checks++; if (time_out !== 39'd0) begin n_fail++; $display("FAIL done_time_out: got %0d expected 0", time_out); end
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      n_checks++; if (fsm_state !== 2'd0 || done !== 1'b0) begin n_fail++; $display("FAIL done_clear: got state=%0d done=%0b expected state=0 done=0", fsm_state, done); end
      cyc(2);
      n_checks++; if (time_out !== 39'd3) begin n_fail++; $display("FAIL clear_reload: got %0d expected 3", time_out); end
   endtask

   task automatic test_lap();
      logic [38:0] exp_v;
      do_reset();
      mode = 1'b0;
      pulse_ss();
      cyc(20);
      lap = 1'b1;
      cyc(1);
      lap = 1'b0;
      n_checks++; if (lap_active !== 1'b1) begin n_fail++; $display("FAIL lap_set: got %0b expected 1", lap_active); end
      for (int k = 0; k < 16; k++) exp_q.push_back(39'd5);
      for (int k = 0; k < 15; k++) begin
         cyc(1);
         exp_v = exp_q.pop_front();
         n_checks++; if (time_out !== exp_v) begin n_fail++; $display("FAIL lap_frozen k=%0d: got %0d expected %0d", k, time_out, exp_v); end
      end
      lap = 1'b1;
      cyc(1);
      lap = 1'b0;
      exp_v = exp_q.pop_front();
      n_checks++; if (time_out !== exp_v || lap_active !== 1'b0) begin n_fail++; $display("FAIL lap_release: got time=%0d lap=%0b expected time=%0d lap=0", time_out, lap_active, exp_v); end
      exp_q.push_back(39'd9);
      cyc(1);
      exp_v = exp_q.pop_front();
      n_checks++; if (time_out !== exp_v) begin n_fail++; $display("FAIL lap_live: got %0d expected %0d", time_out, exp_v); end
   endtask

   task automatic test_clear_priority();
      logic [38:0] exp_v;
      do_reset();
      mode = 1'b0;
      pulse_ss();
      cyc(10);
      clear = 1'b1; start_stop = 1'b1; lap = 1'b1;
      cyc(1);
      clear = 1'b0; start_stop = 1'b0; lap = 1'b0;
      n_checks++; if (running !== 1'b0 || fsm_state !== 2'd0 || lap_active !== 1'b0) begin n_fail++; $display("FAIL clear_prio: got running=%0b state=%0d lap=%0b expected 0/0/0", running, fsm_state, lap_active); end
      cyc(1);
      n_checks++; if (time_out !== 39'd0) begin n_fail++; $display("FAIL clear_time_out: got %0d expected 0", time_out); end
      // Prescaler was mid-phase at the clear; a fresh run needs the full 4 edges.
      pulse_ss();
      for (int k = 1; k <= 5; k++) exp_q.push_back((k == 5) ? 39'd1 : 39'd0);
      for (int k = 1; k <= 5; k++) begin
         cyc(1);
         exp_v = exp_q.pop_front();
         n_checks++; if (time_out !== exp_v) begin n_fail++; $display("FAIL clear_prescaler k=%0d: got %0d expected %0d", k, time_out, exp_v); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      mode = 1'b0;
      pulse_ss();
      cyc(9);
      lap = 1'b1;
      cyc(1);
      lap = 1'b0;
      cyc(2);
      pulse_ss();
      n_checks++; if (lap_active !== 1'b1 || fsm_state !== 2'd2 || time_out !== 39'd2) begin n_fail++; $display("FAIL pre_reset: got lap=%0b state=%0d time=%0d expected lap=1 state=2 time=2", lap_active, fsm_state, time_out); end
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      n_checks++; if (time_out !== 39'd0 || running !== 1'b0 || lap_active !== 1'b0 || done !== 1'b0 || fsm_state !== 2'd0) begin
         n_fail++; $display("FAIL reset_mid: got time=%0d run=%0b lap=%0b done=%0b state=%0d expected all 0", time_out, running, lap_active, done, fsm_state);
      end
   endtask

   task automatic test_down_zero();
      do_reset();
      mode = 1'b1; load_ms = 39'd0;
      cyc(2);
      pulse_ss();
      n_checks++; if (running !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL zero_start: got running=%0b done=%0b expected running=1 done=0", running, done); end
      cyc(1);
      n_checks++; if (done !== 1'b1 || running !== 1'b0 || fsm_state !== 2'd3) begin n_fail++; $display("FAIL zero_done: got done=%0b running=%0b state=%0d expected 1/0/3", done, running, fsm_state); end
   endtask

   task automatic test_clamp();
      logic [38:0] ld_tab[6];
      logic [38:0] exp_v;
      ld_tab = '{39'd5_000_000, 39'd3_600_000, 39'd3_599_999, 39'd3_599_998, 39'd17, 39'h7F_FFFF_FFFF};
      do_reset();
      mode = 1'b1;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back((ld_tab[i] >= 39'd3_600_000) ? 39'd3_599_999 : ld_tab[i]);
         load_ms = ld_tab[i];
         cyc(2);
         exp_v = exp_q.pop_front();
         n_checks++; if (time_out !== exp_v) begin n_fail++; $display("FAIL clamp load=%0d: got %0d expected %0d", ld_tab[i], time_out, exp_v); end
      end
      lap = 1'b1;
      cyc(1);
      lap = 1'b0;
      n_checks++; if (lap_active !== 1'b0) begin n_fail++; $display("FAIL idle_lap: got %0b expected 0", lap_active); end
      mode = 1'b0;
      cyc(2);
      n_checks++; if (time_out !== 39'd0) begin n_fail++; $display("FAIL idle_up_zero: got %0d expected 0", time_out); end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_up_count();
      test_wrap();
      test_countdown();
      test_lap();
      test_clear_priority();
      test_reset_mid();
      test_down_zero();
      test_clamp();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
